// File: rtl/dtl_console_buffered.sv
// DTL console target: write bursts are buffered in a first-word fall-through FIFO drained via valid/accept.
// Define DTL_CONSOLE_STATUS_EN to make read beats return a FIFO status word instead of zero.
module dtl_console_buffered #(
    parameter int INTERFACE_WIDTH       = 32,
    parameter int INTERFACE_ADDR_WIDTH  = 32,
    parameter int INTERFACE_BLOCK_WIDTH = 5,
    parameter int INTERFACE_NUM_ENABLES = INTERFACE_WIDTH / 8,
    parameter int FIFO_DEPTH_LOG2       = 3
) (
    input  logic                             iClk,
    input  logic                             iReset,
    input  logic                             iDTL_CommandValid,
    output logic                             oDTL_CommandAccept,
    input  logic [INTERFACE_ADDR_WIDTH-1:0]  iDTL_Address,
    input  logic                             iDTL_CommandReadWrite,
    input  logic [INTERFACE_BLOCK_WIDTH-1:0] iDTL_BlockSize,
    output logic                             oDTL_ReadValid,
    output logic                             oDTL_ReadLast,
    input  logic                             iDTL_ReadAccept,
    output logic [INTERFACE_WIDTH-1:0]       oDTL_ReadData,
    input  logic                             iDTL_WriteValid,
    input  logic                             iDTL_WriteLast,
    output logic                             oDTL_WriteAccept,
    input  logic [INTERFACE_NUM_ENABLES-1:0] iDTL_WriteEnable,
    input  logic [INTERFACE_WIDTH-1:0]       iDTL_WriteData,
    output logic                             oOutValid,
    input  logic                             iOutAccept,
    output logic [INTERFACE_WIDTH-1:0]       oOutData,
    output logic [INTERFACE_NUM_ENABLES-1:0] oOutEnable,
    output logic                             oFull,
    output logic                             oEmpty
);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int CW    = FIFO_DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    state_t                           r_state;
    logic [INTERFACE_BLOCK_WIDTH-1:0] r_remaining;
    logic [FIFO_DEPTH_LOG2-1:0]       r_wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0]       r_rd_ptr;
    logic [CW-1:0]                    r_count;
    logic [INTERFACE_WIDTH-1:0]       r_mem_data   [DEPTH];
    logic [INTERFACE_NUM_ENABLES-1:0] r_mem_enable [DEPTH];

    logic w_full;
    logic w_empty;
    logic w_last;
    logic w_write_accept;
    logic w_write_beat;
    logic w_push;
    logic w_pop;
    logic w_unused;

    assign w_full         = (r_count == CW'(DEPTH));
    assign w_empty        = (r_count == '0);
    assign w_last         = (r_remaining == '0);
    assign w_write_accept = (r_state == ST_WRITE) && !w_full;
    assign w_write_beat   = w_write_accept && iDTL_WriteValid;
    // Zero-enable beats complete the DTL handshake but carry nothing for the console.
    assign w_push         = w_write_beat && (|iDTL_WriteEnable);
    assign w_pop          = !w_empty && iOutAccept;
    assign w_unused       = ^{iDTL_Address, iDTL_WriteLast};

    assign oDTL_CommandAccept = (r_state == ST_IDLE) && !iReset;
    assign oDTL_WriteAccept   = w_write_accept;
    assign oDTL_ReadValid     = (r_state == ST_READ);
    assign oDTL_ReadLast      = (r_state == ST_READ) && w_last;
    assign oOutValid          = !w_empty;
    assign oOutData           = r_mem_data[r_rd_ptr];
    assign oOutEnable         = r_mem_enable[r_rd_ptr];
    assign oFull              = w_full;
    assign oEmpty             = w_empty;

`ifdef DTL_CONSOLE_STATUS_EN
    logic [INTERFACE_WIDTH-1:0] w_status;
    always_comb begin
        w_status       = '0;
        w_status[15:0] = 16'(r_count);
        w_status[16]   = w_full;
        w_status[17]   = w_empty;
    end
    assign oDTL_ReadData = (r_state == ST_READ) ? w_status : '0;
`else
    assign oDTL_ReadData = '0;
`endif

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (iDTL_CommandValid) begin
                        r_remaining <= iDTL_BlockSize;
                        r_state     <= iDTL_CommandReadWrite ? ST_READ : ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (w_write_beat) begin
                        if (w_last) r_state <= ST_IDLE;
                        else        r_remaining <= r_remaining - INTERFACE_BLOCK_WIDTH'(1);
                    end
                end
                ST_READ: begin
                    if (iDTL_ReadAccept) begin
                        if (w_last) r_state <= ST_IDLE;
                        else        r_remaining <= r_remaining - INTERFACE_BLOCK_WIDTH'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + FIFO_DEPTH_LOG2'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + FIFO_DEPTH_LOG2'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge iClk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr]   <= iDTL_WriteData;
            r_mem_enable[r_wr_ptr] <= iDTL_WriteEnable;
        end
    end

endmodule

// File: tb/tb_dtl_console_buffered.sv
// Bench for dtl_console_buffered: randomized DTL bursts, expected console words queued by the driver
// and popped by a monitor that also tracks a transaction-level model of the FIFO and burst progress.
module tb_dtl_console_buffered;
    localparam int W     = 32;
    localparam int AW    = 32;
    localparam int BW    = 5;
    localparam int NE    = 4;
    localparam int LOG2  = 3;
    localparam int DEPTH = 8;

    logic          iClk;
    logic          iReset;
    logic          iDTL_CommandValid;
    logic          oDTL_CommandAccept;
    logic [AW-1:0] iDTL_Address;
    logic          iDTL_CommandReadWrite;
    logic [BW-1:0] iDTL_BlockSize;
    logic          oDTL_ReadValid;
    logic          oDTL_ReadLast;
    logic          iDTL_ReadAccept;
    logic [W-1:0]  oDTL_ReadData;
    logic          iDTL_WriteValid;
    logic          iDTL_WriteLast;
    logic          oDTL_WriteAccept;
    logic [NE-1:0] iDTL_WriteEnable;
    logic [W-1:0]  iDTL_WriteData;
    logic          oOutValid;
    logic          iOutAccept;
    logic [W-1:0]  oOutData;
    logic [NE-1:0] oOutEnable;
    logic          oFull;
    logic          oEmpty;

    dtl_console_buffered #(
        .INTERFACE_WIDTH(W), .INTERFACE_ADDR_WIDTH(AW), .INTERFACE_BLOCK_WIDTH(BW),
        .INTERFACE_NUM_ENABLES(NE), .FIFO_DEPTH_LOG2(LOG2)
    ) dut (
        .iClk(iClk), .iReset(iReset),
        .iDTL_CommandValid(iDTL_CommandValid), .oDTL_CommandAccept(oDTL_CommandAccept),
        .iDTL_Address(iDTL_Address), .iDTL_CommandReadWrite(iDTL_CommandReadWrite),
        .iDTL_BlockSize(iDTL_BlockSize),
        .oDTL_ReadValid(oDTL_ReadValid), .oDTL_ReadLast(oDTL_ReadLast),
        .iDTL_ReadAccept(iDTL_ReadAccept), .oDTL_ReadData(oDTL_ReadData),
        .iDTL_WriteValid(iDTL_WriteValid), .iDTL_WriteLast(iDTL_WriteLast),
        .oDTL_WriteAccept(oDTL_WriteAccept), .iDTL_WriteEnable(iDTL_WriteEnable),
        .iDTL_WriteData(iDTL_WriteData),
        .oOutValid(oOutValid), .iOutAccept(iOutAccept), .oOutData(oOutData),
        .oOutEnable(oOutEnable), .oFull(oFull), .oEmpty(oEmpty)
    );

    // ---------------- clock / reset ----------------
    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [W+NE-1:0] exp_q[$];
    int cons_mode = 0;   // 0: never accept, 1: always accept, 2: random
    logic [W-1:0]  wd[64];
    logic [NE-1:0] we[64];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    // ---------------- reference model + monitor ----------------
    int m_mode  = 0;   // 0 idle, 1 write burst, 2 read burst
    int m_rem   = 0;
    int m_count = 0;

    always @(negedge iClk) begin
        logic [W-1:0] exp_rd;
        logic         m_wacc;
        logic [W+NE-1:0] e;
        if (iReset) begin
            m_mode = 0; m_rem = 0; m_count = 0;
            exp_q.delete();
            check("rst_cmd_accept", 64'(oDTL_CommandAccept), 64'(0));
            check("rst_out_valid", 64'(oOutValid), 64'(0));
            check("rst_empty", 64'(oEmpty), 64'(1));
            check("rst_read_data", 64'(oDTL_ReadData), 64'(0));
        end else begin
            m_wacc = (m_mode == 1) && (m_count != DEPTH);
            exp_rd = '0;
`ifdef DTL_CONSOLE_STATUS_EN
            exp_rd = W'(m_count) | (W'(m_count == DEPTH) << 16) | (W'(m_count == 0) << 17);
`endif
            check("cmd_accept", 64'(oDTL_CommandAccept), 64'(m_mode == 0));
            check("write_accept", 64'(oDTL_WriteAccept), 64'(m_wacc));
            check("read_valid", 64'(oDTL_ReadValid), 64'(m_mode == 2));
            check("read_last", 64'(oDTL_ReadLast), 64'((m_mode == 2) && (m_rem == 0)));
            if (m_mode == 2) check("read_data", 64'(oDTL_ReadData), 64'(exp_rd));
            check("out_valid", 64'(oOutValid), 64'(m_count != 0));
            check("full", 64'(oFull), 64'(m_count == DEPTH));
            check("empty", 64'(oEmpty), 64'(m_count == 0));
            if (oOutValid && iOutAccept) begin
                if (exp_q.size() == 0) begin
                    check("out_unexpected", 64'({oOutEnable, oOutData}), 64'(0) - 64'(1));
                end else begin
                    e = exp_q.pop_front();
                    check("out_word", 64'({oOutEnable, oOutData}), 64'(e));
                end
            end
            // advance the model to what the coming edge should do
            if (m_wacc && iDTL_WriteValid && (iDTL_WriteEnable != '0)) m_count++;
            if ((m_count != 0) && iOutAccept && oOutValid) m_count--;
            if (m_mode == 0) begin
                if (iDTL_CommandValid) begin
                    m_mode = iDTL_CommandReadWrite ? 2 : 1;
                    m_rem  = int'(iDTL_BlockSize);
                end
            end else if ((m_mode == 1 && m_wacc && iDTL_WriteValid) ||
                         (m_mode == 2 && iDTL_ReadAccept)) begin
                if (m_rem == 0) m_mode = 0;
                else m_rem--;
            end
        end
    end

    // ---------------- console consumer ----------------
    always @(posedge iClk) begin
        #1;
        case (cons_mode)
            0:       iOutAccept = 1'b0;
            1:       iOutAccept = 1'b1;
            default: iOutAccept = ($urandom_range(0, 2) != 0);
        endcase
    end

    // ---------------- driver tasks ----------------
    task automatic send_cmd(input logic rw, input int bs);
        logic acc;
        acc = 1'b0;
        iDTL_CommandValid     = 1'b1;
        iDTL_CommandReadWrite = rw;
        iDTL_BlockSize        = BW'(bs);
        iDTL_Address          = $urandom;
        for (int t = 0; t < 200; t++) begin
            @(negedge iClk);
            acc = oDTL_CommandAccept;
            @(posedge iClk);
            #1;
            if (acc) break;
        end
        iDTL_CommandValid = 1'b0;
        if (!acc) fail_now("cmd_timeout");
    endtask

    task automatic write_burst(input int bs, input int nb);
        logic acc;
        send_cmd(1'b0, bs);
        for (int b = 0; b < nb; b++) begin
            iDTL_WriteValid  = 1'b1;
            iDTL_WriteData   = wd[b];
            iDTL_WriteEnable = we[b];
            iDTL_WriteLast   = (b == bs);
            acc = 1'b0;
            for (int t = 0; t < 500; t++) begin
                @(negedge iClk);
                acc = oDTL_WriteAccept;
                if (acc && (we[b] != '0)) exp_q.push_back({we[b], wd[b]});
                @(posedge iClk);
                #1;
                if (acc) break;
            end
            if (!acc) fail_now("write_beat_timeout");
        end
        iDTL_WriteValid = 1'b0;
        iDTL_WriteLast  = 1'b0;
    endtask

    task automatic read_burst(input int bs);
        int   got;
        logic tog;
        got = 0;
        tog = 1'b0;
        send_cmd(1'b1, bs);
        for (int t = 0; t < 200 && got <= bs; t++) begin
            iDTL_ReadAccept = tog;
            tog = ~tog;
            @(negedge iClk);
            if (oDTL_ReadValid && iDTL_ReadAccept) got++;
            @(posedge iClk);
            #1;
        end
        iDTL_ReadAccept = 1'b0;
        check("read_beats", 64'(got), 64'(bs + 1));
    endtask

    task automatic drain();
        cons_mode = 1;
        for (int t = 0; t < 300 && exp_q.size() != 0; t++) @(posedge iClk);
        repeat (2) @(posedge iClk);
        #1;
        check("drain_left", 64'(exp_q.size()), 64'(0));
        cons_mode = 0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        iReset = 1'b1;
        iDTL_CommandValid = 1'b0; iDTL_Address = '0; iDTL_CommandReadWrite = 1'b0;
        iDTL_BlockSize = '0; iDTL_ReadAccept = 1'b0; iDTL_WriteValid = 1'b0;
        iDTL_WriteLast = 1'b0; iDTL_WriteEnable = '0; iDTL_WriteData = '0;
        iOutAccept = 1'b0;
        repeat (3) @(posedge iClk);
        #1 iReset = 1'b0;
        repeat (2) @(posedge iClk);
        #1;

        // single word, consumer stalled
        cons_mode = 0;
        wd[0] = 32'h0000_00AB; we[0] = 4'hF;
        write_burst(0, 1);
        @(negedge iClk);
        check("single_head_data", 64'(oOutData), 64'h0000_00AB);
        check("single_head_valid", 64'(oOutValid), 64'(1));
        drain();

        // back-pressure: ten words into an eight-deep FIFO
        for (int i = 0; i < 10; i++) begin wd[i] = W'(i + 1); we[i] = 4'hF; end
        fork
            write_burst(9, 10);
            begin
                repeat (20) @(posedge iClk);
                @(negedge iClk);
                check("bp_full", 64'(oFull), 64'(1));
                check("bp_write_stall", 64'(oDTL_WriteAccept), 64'(0));
                cons_mode = 1;
            end
        join
        drain();

        // zero-enable beat is consumed but not buffered
        wd[0] = 32'h11; we[0] = 4'hF;
        wd[1] = 32'h22; we[1] = 4'h0;
        wd[2] = 32'h33; we[2] = 4'hF;
        write_burst(2, 3);
        drain();

        // read burst with five words parked in the FIFO
        for (int i = 0; i < 5; i++) begin wd[i] = $urandom; we[i] = 4'hF; end
        write_burst(4, 5);
        read_burst(3);
        drain();

        // async reset in the middle of a six-beat burst
        for (int i = 0; i < 6; i++) begin wd[i] = $urandom; we[i] = 4'hF; end
        write_burst(5, 3);
        @(negedge iClk);
        #2 iReset = 1'b1;
        #1;
        check("async_cmd_accept", 64'(oDTL_CommandAccept), 64'(0));
        check("async_write_accept", 64'(oDTL_WriteAccept), 64'(0));
        check("async_out_valid", 64'(oOutValid), 64'(0));
        check("async_full", 64'(oFull), 64'(0));
        check("async_empty", 64'(oEmpty), 64'(1));
        exp_q.delete();
        repeat (2) @(posedge iClk);
        #1 iReset = 1'b0;
        @(posedge iClk);
        #1;
        wd[0] = 32'h0000_005A; we[0] = 4'h3;
        write_burst(0, 1);
        drain();

        // randomized traffic with a random consumer
        cons_mode = 2;
        for (int n = 0; n < 40; n++) begin
            int bs;
            bs = $urandom_range(0, 11);
            if ($urandom_range(0, 3) == 0) begin
                read_burst(bs);
            end else begin
                for (int i = 0; i <= bs; i++) begin
                    wd[i] = $urandom;
                    we[i] = ($urandom_range(0, 3) == 0) ? 4'h0 : NE'($urandom_range(1, 15));
                end
                write_burst(bs, bs + 1);
            end
            cons_mode = 2;
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dtl_console_buffered.md
Name: dtl_console_buffered

Overview:
- Parametrised successor to the console sink: a DTL target that buffers console write bursts in a FIFO with a parametrised depth.
- The FIFO drains through a valid/accept output port, so a slow console consumer back-pressures the DTL initiator through oDTL_WriteAccept.
- DTL reads are serviced: they return zero, or a FIFO status word when the optional feature is compiled in.
- Sits on the DTL interconnect in place of the unbuffered console port.

Parameters:
INTERFACE_WIDTH, 32, data word width (must be >= 18)
INTERFACE_ADDR_WIDTH, 32, DTL address width (address accepted, otherwise unused)
INTERFACE_BLOCK_WIDTH, 5, DTL block size width; burst length = BlockSize+1 words
INTERFACE_NUM_ENABLES, INTERFACE_WIDTH/8, byte enables per word
FIFO_DEPTH_LOG2, 3, FIFO depth = 2**FIFO_DEPTH_LOG2 entries (legal range 1..15)

Ports:
iClk  in  1  clock, all logic on rising edge
iReset  in  1  asynchronous, active-high reset
iDTL_CommandValid  in  1  command valid
oDTL_CommandAccept  out  1  command accept
iDTL_Address  in  INTERFACE_ADDR_WIDTH  command address (ignored)
iDTL_CommandReadWrite  in  1  1=read, 0=write
iDTL_BlockSize  in  INTERFACE_BLOCK_WIDTH  burst length minus one
oDTL_ReadValid  out  1  read data valid
oDTL_ReadLast  out  1  last read beat
iDTL_ReadAccept  in  1  read beat accept
oDTL_ReadData  out  INTERFACE_WIDTH  read data
iDTL_WriteValid  in  1  write beat valid
iDTL_WriteLast  in  1  last write beat (informational)
oDTL_WriteAccept  out  1  write beat accept
iDTL_WriteEnable  in  INTERFACE_NUM_ENABLES  byte enables
iDTL_WriteData  in  INTERFACE_WIDTH  write data
oOutValid  out  1  FIFO head valid (FIFO not empty)
iOutAccept  in  1  consumer pops head
oOutData  out  INTERFACE_WIDTH  FIFO head data
oOutEnable  out  INTERFACE_NUM_ENABLES  FIFO head byte enables
oFull  out  1  FIFO count == depth
oEmpty  out  1  FIFO count == 0

Behaviour:
- Reset (async, takes effect immediately):
  - FSM goes to IDLE; rd/wr pointers = 0; count = 0; remaining-beat counter = 0.
  - Outputs during reset: oDTL_CommandAccept=0, ReadValid=0, ReadLast=0, WriteAccept=0, oOutValid=0, oFull=0, oEmpty=1, ReadData=0.
  - Reset mid-burst discards the burst and all buffered words.
- FSM states: IDLE, WRITE, READ. No reset state.
- IDLE:
  - oDTL_CommandAccept=1 (while not in reset).
  - On CommandValid: latch remaining=BlockSize; go to READ if ReadWrite=1, else WRITE.
  - CommandAccept=0 in WRITE and READ, so there is no back-to-back command overlap (one IDLE cycle between bursts).
- WRITE:
  - oDTL_WriteAccept = !oFull (combinational).
  - A beat transfers when WriteValid && WriteAccept.
  - Beat with any enable set: push {data, enables}.
  - Beat with all enables 0: consumed but not pushed.
  - Per transferred beat: if remaining==0, go to IDLE; else remaining-1.
  - WriteLast is not used for termination; the block size governs.
- READ:
  - oDTL_ReadValid=1; oDTL_ReadLast = (remaining==0).
  - On ReadAccept: if last, go to IDLE; else remaining-1.
  - ReadData is sampled combinationally from the current state every beat.
- FIFO:
  - Register array; first-word fall-through.
  - oOutData/oOutEnable = mem[rd_ptr].
  - Pop when oOutValid && iOutAccept.
  - A word pushed in cycle N is visible on oOutValid in cycle N+1.
  - Pointers wrap modulo depth; count is FIFO_DEPTH_LOG2+1 bits wide.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - When full, WriteAccept=0 even if a pop happens the same cycle; the push is taken next cycle.
  - Pop when empty is impossible, since oOutValid=0.
- oFull and oEmpty are derived from the registered count.

Optional Feature:
- Macro: DTL_CONSOLE_STATUS_EN
- Defined: read beats return a status word.
  - [15:0] = count, zero-extended.
  - [16] = oFull.
  - [17] = oEmpty.
  - [31:18] = 0 (upper bits 0 for any width).
  - Value reflects the cycle the beat is presented.
- Undefined: oDTL_ReadData is constant 0; read handshake is unchanged.

Test Plan:
- Single write: BlockSize=0, data 0x000000AB, enables 4'hF, iOutAccept=0 -> WriteAccept=1 in the beat cycle; next cycle oOutValid=1, oOutData=0x000000AB, oEmpty=0; FSM back in IDLE with CommandAccept=1.
- Back-pressure: depth 8, BlockSize=9, words 1..10, iOutAccept=0 -> 8 beats accepted; oFull=1; WriteAccept=0. Raise iOutAccept -> words 9,10 accepted; output order 1..10; remaining beats reach 0, then IDLE.
- Zero-enable beat: BlockSize=2, enables F,0,F, data 0x11,0x22,0x33 -> all 3 beats accepted; FIFO delivers only 0x11, 0x33.
- Read burst: BlockSize=3 with ReadAccept toggling every other cycle -> exactly 4 accepted beats, ReadLast only on the 4th. With DTL_CONSOLE_STATUS_EN and 5 words queued, ReadData=0x00000005; without it, ReadData=0.
- Simultaneous push/pop: count=4, one write beat plus one pop in the same cycle -> count stays 4; data order preserved; pointer wrap past entry 7 is seen correctly.
- Async reset mid-burst: assert iReset between clock edges after 3 of 6 write beats -> outputs take their reset values before the next edge; oEmpty=1. After release, a new single write completes normally.
